// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter: the serializer state
// encoding and the 8N1 framing constants.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    // Serializer phases of one 8N1 frame
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin request picker: starting at index i_ptr, returns the first
// asserted request (wrapping modulo NREQ).
// Ports:
//   i_req     in  NREQ  request vector
//   i_ptr     in  3     highest-priority index this cycle
//   i_enable  in  1     when low no grant is produced
//   o_grant   out NREQ  one-hot grant (all zero if nothing granted)
//   o_index   out 3     index of the granted request
//   o_valid   out 1     a grant was produced
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [2:0]      i_ptr,
    input  logic            i_enable,
    output logic [NREQ-1:0] o_grant,
    output logic [2:0]      o_index,
    output logic            o_valid
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    int            w_idx;
    logic [PW-1:0] w_sel;
    logic          w_found;

    // Walk the requests in priority order ptr, ptr+1, ... and keep the first hit
    always_comb begin
        o_grant = '0;
        o_index = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            w_sel = PW'(w_idx);
            if (i_enable && !w_found && i_req[w_sel]) begin
                o_grant[w_sel] = 1'b1;
                o_index        = 3'(w_sel);
                w_found        = 1'b1;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmit pin among NREQ byte producers. A round-robin
// arbiter picks a pending byte while idle; an 8N1 serializer shifts it out
// LSB first with DIV clock cycles per bit.
// Ports:
//   clk        in  1       system clock, rising edge
//   rst        in  1       asynchronous reset, active low
//   req_valid  in  NREQ    requester i has a byte pending
//   req_data   in  8*NREQ  byte of requester i at [8*i+7:8*i]
//   req_ready  out NREQ    one-hot accept (combinational, idle only)
//   uart_tx    out 1       serial line, idle high, registered
//   busy       out 1       a frame is in progress
//   grant_id   out 3       requester whose byte is/was last sent
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DIV  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_tx,
    output logic              busy,
    output logic [2:0]        grant_id
);

    localparam int BW = $clog2(DIV);

    tx_state_t       r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [2:0]      r_ptr;
    logic [2:0]      r_grantId;
    logic            r_tx;

    logic [NREQ-1:0] w_grant;
    logic [2:0]      w_index;
    logic            w_win;
    logic [7:0]      w_selData;
    logic            w_baudDone;

    // Grants are only offered while idle and never while reset is held,
    // so no byte can be taken during reset.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .i_enable ((r_state == IDLE) && rst),
        .o_grant  (w_grant),
        .o_index  (w_index),
        .o_valid  (w_win)
    );

    // Byte of the winning requester, picked with constant slices
    always_comb begin
        w_selData = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_selData = req_data[8*i +: 8];
            end
        end
    end

    assign w_baudDone = (r_baud == BW'(DIV - 1));

    // Frame sequencer: the line level for the next cycle is registered
    // together with the state change, so tx falls one cycle after accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_grantId <= '0;
            r_tx      <= IDLE_LEVEL;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_win) begin
                        r_shift   <= w_selData;
                        r_grantId <= w_index;
                        r_ptr     <= (w_index == 3'(NREQ - 1)) ? 3'd0 : w_index + 3'd1;
                        r_tx      <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_baudDone) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                DATA: begin
                    if (w_baudDone) begin
                        r_baud <= '0;
                        if (r_bit == 3'(DATA_BITS - 1)) begin
                            r_tx    <= IDLE_LEVEL;
                            r_state <= STOP;
                        end else begin
                            // Next bit comes from position 1 of the pre-shift value
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                STOP: begin
                    if (w_baudDone) begin
                        r_baud  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

    assign req_ready = w_grant;
    assign uart_tx   = r_tx;
    assign busy      = (r_state != IDLE);
    assign grant_id  = r_grantId;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter with NREQ=4, DIV=4. A frame-level
// model (accept time + byte -> line level by arithmetic) predicts every
// output each cycle; directed sequences add literal expectations, then
// randomized producers exercise the arbiter.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DIV  = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              uart_tx;
    logic              busy;
    logic [2:0]        grant_id;

    int vectors;
    int miscompares;

    // Frame-level model state
    bit              mActive;
    int              mAcc;
    logic [7:0]      mByte;
    int              mPtr;
    int              mGrant;
    int              cyc;
    logic [NREQ-1:0] lastAccept;

    uart_tx_arbiter #(.NREQ(NREQ), .DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; every failing one prints a FAIL line
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Line level implied by an accept k cycles before the start bit
    function automatic logic frameLevel(input int k, input logic [7:0] b);
        int bitPos;
        bitPos = k / DIV;
        if (bitPos == 0) return 1'b0;
        if (bitPos <= 8) return b[bitPos-1];
        return 1'b1;
    endfunction

    // Model + compare process: predicts outputs from the accept history and
    // the current requests, checks them, then commits any new accept.
    always @(negedge clk) begin
        int k;
        int idx;
        int win;
        bit idle;
        logic expTx;
        logic expBusy;
        logic [NREQ-1:0] expReady;
        lastAccept = '0;
        expReady   = '0;
        win        = 0;
        if (!rst) begin
            mActive = 0;
            mPtr    = 0;
            mGrant  = 0;
            expTx   = 1'b1;
            expBusy = 1'b0;
        end else begin
            k    = cyc - mAcc - 1;
            idle = !mActive || (k >= 10 * DIV);
            if (idle) begin
                expTx   = 1'b1;
                expBusy = 1'b0;
                for (int j = 0; j < NREQ; j++) begin
                    idx = (mPtr + j) % NREQ;
                    if (expReady == '0 && req_valid[idx]) begin
                        expReady[idx] = 1'b1;
                        win = idx;
                    end
                end
            end else begin
                expTx   = frameLevel(k, mByte);
                expBusy = 1'b1;
            end
        end
        checkOutput("uart_tx", 32'(uart_tx), 32'(expTx));
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        checkOutput("grant_id", 32'(grant_id), 32'(mGrant));
        if (expReady != '0) begin
            mActive    = 1;
            mAcc       = cyc;
            mByte      = req_data[8*win +: 8];
            mGrant     = win;
            mPtr       = (win + 1) % NREQ;
            lastAccept = expReady;
        end
        cyc++;
    end

    // Wait (bounded) for the next accept; n = negedges waited
    task automatic waitAccept(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 200);
        if (req_ready == '0) checkOutput("accept_timeout", 32'(n), 32'd0);
    endtask

    // Wait (bounded) until the serializer is idle again
    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) checkOutput("idle_timeout", 32'(n), 32'd0);
    endtask

    // Literal check of a whole frame, starting at the start-bit cycle
    task automatic checkFrame(input string name, input logic [9:0] pat);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                if (c == DIV / 2) checkOutput(name, 32'(uart_tx), 32'(pat[b]));
                if (c == 0) checkOutput({name, "_busy"}, 32'(busy), 32'd1);
            end
        end
    endtask

    initial begin
        int n;
        int readySeen;
        logic [NREQ-1:0] expOrder [5];
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        mActive     = 0;
        mAcc        = 0;
        mByte       = '0;
        mPtr        = 0;
        mGrant      = 0;
        rst         = 1'b0;
        req_valid   = '0;
        req_data    = '0;

        // Power-on reset
        repeat (3) applyStimulus();
        checkOutput("reset_tx", 32'(uart_tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_grant", 32'(grant_id), 32'd0);
        rst = 1'b1;
        applyStimulus();

        // Frame from requester 1 moves the pointer to 2
        req_valid = 4'b0010;
        req_data[15:8] = 8'h11;
        @(negedge clk);
        checkOutput("t4_setup_ready", 32'(req_ready), 32'b0010);
        applyStimulus();
        req_valid = '0;
        waitIdle();

        // Pointer at 2, requests 3 and 0: 3 first, then 0 one frame later
        applyStimulus();
        req_valid = 4'b1001;
        req_data[31:24] = 8'hC3;
        req_data[7:0]   = 8'h3C;
        @(negedge clk);
        checkOutput("t4_first", 32'(req_ready), 32'b1000);
        applyStimulus();
        req_valid[3] = 1'b0;
        waitAccept(n);
        checkOutput("t4_second", 32'(req_ready), 32'b0001);
        checkOutput("t4_pitch", 32'(n), 32'd41);
        applyStimulus();
        req_valid = '0;
        waitIdle();

        // Single byte A5 from requester 2
        applyStimulus();
        req_valid = 4'b0100;
        req_data[23:16] = 8'hA5;
        @(negedge clk);
        checkOutput("t2_ready", 32'(req_ready), 32'b0100);
        applyStimulus();
        req_valid = '0;
        checkFrame("t2_bit", 10'b1101001010);
        @(negedge clk);
        checkOutput("t2_busy_end", 32'(busy), 32'd0);
        checkOutput("t2_grant", 32'(grant_id), 32'd2);

        // Reset in the middle of DATA with everyone requesting
        applyStimulus();
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'h30 + 8'(i);
        req_valid = 4'b1111;
        @(negedge clk);
        checkOutput("t1_pre_ready", 32'(req_ready), 32'b1000);
        repeat (3 * DIV) applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("t1_tx", 32'(uart_tx), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        checkOutput("t1_ready", 32'(req_ready), 32'd0);
        repeat (2) applyStimulus();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t1_first_after_reset", 32'(req_ready), 32'b0001);

        // All requesting: strict rotation at a 41-cycle pitch
        expOrder[0] = 4'b0010;
        expOrder[1] = 4'b0100;
        expOrder[2] = 4'b1000;
        expOrder[3] = 4'b0001;
        for (int r = 0; r < 4; r++) begin
            waitAccept(n);
            checkOutput("t3_order", 32'(req_ready), 32'(expOrder[r]));
            checkOutput("t3_pitch", 32'(n), 32'd41);
        end
        applyStimulus();
        req_valid = '0;

        // Requester 1 withdraws before the frame ends: nothing is taken
        repeat (5) applyStimulus();
        req_valid[1]   = 1'b1;
        req_data[15:8] = 8'h77;
        repeat (10) applyStimulus();
        req_valid[1] = 1'b0;
        readySeen = 0;
        repeat (60) begin
            @(negedge clk);
            if (req_ready != '0) readySeen++;
        end
        checkOutput("t5_no_ready", 32'(readySeen), 32'd0);
        checkOutput("t5_tx_high", 32'(uart_tx), 32'd1);

        // Requester 0 changes its data while its frame is on the line
        applyStimulus();
        req_valid = 4'b0001;
        req_data[7:0] = 8'h5A;
        @(negedge clk);
        checkOutput("t6_ready", 32'(req_ready), 32'b0001);
        applyStimulus();
        req_valid = '0;
        req_data[7:0] = 8'hFF;
        checkFrame("t6_bit", 10'b1010110100);

        // Randomized producers obeying valid/ready
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && lastAccept[i]) begin
                    req_valid[i] = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 49) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
        applyStimulus();
        req_valid = '0;
        waitIdle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
